// File: rtl/fft_stage_sequencer_if.sv
// Control/status bundle between an FFT datapath controller and the stage
// sequencer.
//   start, abort, en, cont, inv_in      : requests from the controller
//   stage_sel, bfly_base, tw_addr       : mux/ROM selects for the current beat
//   valid, stage_first, frame_last      : beat qualifiers
//   busy, done, inv_q, frame_cnt        : frame status
interface fft_stage_sequencer_if #(
  parameter int unsigned LOG2N   = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned FRAME_W = 8
);
  localparam int unsigned AW = LOG2N - 1;

  logic               start;
  logic               abort;
  logic               en;
  logic               cont;
  logic               inv_in;
  logic [SEL_W-1:0]   stage_sel;
  logic [AW-1:0]      bfly_base;
  logic [AW-1:0]      tw_addr;
  logic               valid;
  logic               stage_first;
  logic               frame_last;
  logic               busy;
  logic               done;
  logic               inv_q;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output start, abort, en, cont, inv_in,
    input  stage_sel, bfly_base, tw_addr, valid, stage_first, frame_last,
           busy, done, inv_q, frame_cnt
  );

  modport slave (
    input  start, abort, en, cont, inv_in,
    output stage_sel, bfly_base, tw_addr, valid, stage_first, frame_last,
           busy, done, inv_q, frame_cnt
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT stage sequencer for an N = 2^LOG2N point FFT with
// P = 2^LOG2P butterflies per beat. Each beat emits the stage select,
// lane-0 butterfly index and lane-0 twiddle exponent.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   sq  : control/status bundle (slave side), see fft_stage_sequencer_if
module fft_stage_sequencer #(
  parameter int unsigned LOG2N   = 5,
  parameter int unsigned LOG2P   = 4,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned FRAME_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_stage_sequencer_if.slave  sq
);
  localparam int unsigned AW         = LOG2N - 1;
  localparam int unsigned CW         = LOG2N - 1 - LOG2P;
  localparam int unsigned BW         = (CW == 0) ? 1 : CW;
  localparam int unsigned C_LAST     = (1 << CW) - 1;
  localparam int unsigned LAST_STAGE = LOG2N - 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   stage_q, stage_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [AW-1:0]      base_q, base_d;
  logic [AW-1:0]      tw_q, tw_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               inv_q, inv_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic               issue;
  logic [AW:0]        mask;
  logic [SEL_W-1:0]   sh;

  // Next-state and next-output logic; a beat is issued whenever 'issue' is set.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bcnt_d  = bcnt_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sq.start && !sq.abort) begin
          state_d = S_RUN;
          inv_d   = sq.inv_in;
          stage_d = '0;
          bcnt_d  = '0;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        if (sq.abort) begin
          state_d = S_IDLE;
        end else if (last_q) begin
          // Final beat was presented last cycle: close the frame.
          done_d = 1'b1;
          cnt_d  = cnt_q + FRAME_W'(1);
          if (sq.cont) begin
            inv_d   = sq.inv_in;
            stage_d = '0;
            bcnt_d  = '0;
            issue   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sq.en) begin
          issue = 1'b1;
          if (bcnt_q == BW'(C_LAST)) begin
            bcnt_d  = '0;
            stage_d = stage_q + SEL_W'(1);
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_RUN);
    valid_d = issue;
    first_d = issue && (bcnt_d == '0);
    last_d  = issue && (stage_d == SEL_W'(LAST_STAGE)) && (bcnt_d == BW'(C_LAST));

    // Index outputs track the beat position, so they hold while stalled.
    base_d = AW'(bcnt_d) << LOG2P;
    mask   = ((AW+1)'(1) << stage_d) - (AW+1)'(1);
    sh     = SEL_W'(AW) - stage_d;
    tw_d   = AW'({1'b0, base_d} & mask) << sh;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bcnt_q  <= '0;
      base_q  <= '0;
      tw_q    <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bcnt_q  <= bcnt_d;
      base_q  <= base_d;
      tw_q    <= tw_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sq.stage_sel   = stage_q;
  assign sq.bfly_base   = base_q;
  assign sq.tw_addr     = tw_q;
  assign sq.valid       = valid_q;
  assign sq.stage_first = first_q;
  assign sq.frame_last  = last_q;
  assign sq.busy        = busy_q;
  assign sq.done        = done_q;
  assign sq.inv_q       = inv_q;
  assign sq.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: two instances (LOG2N=5/LOG2P=4 and
// LOG2N=3/LOG2P=0) driven by directed and random control, checked per cycle
// against a beat-list reference model through expectation queues.
module tb_fft_stage_sequencer;
  typedef struct {
    bit busy;
    int idx;
    bit valid;
    bit sf;
    bit fl;
    bit done;
    bit inv;
    int stage;
    int base;
    int tw;
    int cnt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst5, rst3;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.LOG2N(5), .SEL_W(3), .FRAME_W(8)) i5 ();
  fft_stage_sequencer_if #(.LOG2N(3), .SEL_W(2), .FRAME_W(8)) i3 ();

  fft_stage_sequencer #(.LOG2N(5), .LOG2P(4), .SEL_W(3), .FRAME_W(8)) u5 (
    .clk(clk), .rst(rst5), .sq(i5.slave));
  fft_stage_sequencer #(.LOG2N(3), .LOG2P(0), .SEL_W(2), .FRAME_W(8)) u3 (
    .clk(clk), .rst(rst3), .sq(i3.slave));

  mdl_t m5, m3;
  mdl_t q5[$];
  mdl_t q3[$];
  int total = 0;
  int bad   = 0;

  // Beat k of a frame, straight from the stage/butterfly arithmetic.
  function automatic mdl_t show(mdl_t m, int k, int ln, int lp);
    int c, b;
    c = 1 << (ln - 1 - lp);
    m.idx   = k;
    m.stage = k / c;
    b       = k % c;
    m.base  = b << lp;
    m.tw    = (m.base % (1 << m.stage)) << (ln - 1 - m.stage);
    m.valid = 1'b1;
    m.sf    = (b == 0);
    m.fl    = (k == ln * c - 1);
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, bit [5:0] in, int ln, int lp);
    bit r, s, a, e, c, v, was_last;
    {r, s, a, e, c, v} = in;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    was_last = m.valid && m.fl;
    m.done  = 1'b0;
    m.valid = 1'b0;
    m.sf    = 1'b0;
    m.fl    = 1'b0;
    if (!m.busy) begin
      if (s && !a) begin
        m.busy = 1'b1;
        m.inv  = v;
        m = show(m, 0, ln, lp);
      end
    end else if (a) begin
      m.busy = 1'b0;
    end else if (was_last) begin
      m.done = 1'b1;
      m.cnt  = (m.cnt + 1) % 256;
      if (c) begin
        m.inv = v;
        m = show(m, 0, ln, lp);
      end else begin
        m.busy = 1'b0;
      end
    end else if (e) begin
      m = show(m, m.idx + 1, ln, lp);
    end
    return m;
  endfunction

  function automatic bit [5:0] mk(bit r, bit s, bit a, bit e, bit c, bit v);
    return {r, s, a, e, c, v};
  endfunction

  function automatic bit [5:0] rnd();
    return mk($urandom_range(199) == 0, $urandom_range(3) == 0,
              $urandom_range(39) == 0, $urandom_range(3) != 0,
              1'($urandom_range(1)), 1'($urandom_range(1)));
  endfunction

  // One cycle: drive both instances and queue what the next edge must produce.
  task automatic cyc2(input bit [5:0] a5, input bit [5:0] a3);
    @(negedge clk);
    {rst5, i5.start, i5.abort, i5.en, i5.cont, i5.inv_in} = a5;
    {rst3, i3.start, i3.abort, i3.en, i3.cont, i3.inv_in} = a3;
    m5 = step(m5, a5, 5, 4);
    m3 = step(m3, a3, 3, 0);
    q5.push_back(m5);
    q3.push_back(m3);
  endtask

  task automatic cyc(input bit [5:0] a);
    cyc2(a, a);
  endtask

  task automatic cmp(input string nm, input mdl_t e, input mdl_t g);
    total++;
    if (e.valid !== g.valid || e.sf !== g.sf || e.fl !== g.fl ||
        e.busy !== g.busy || e.done !== g.done || e.inv !== g.inv ||
        e.stage != g.stage || e.base != g.base || e.tw != g.tw ||
        e.cnt != g.cnt) begin
      bad++;
      $display("FAIL %s t=%0t got v=%0b sf=%0b fl=%0b busy=%0b done=%0b inv=%0b stg=%0d base=%0d tw=%0d cnt=%0d exp v=%0b sf=%0b fl=%0b busy=%0b done=%0b inv=%0b stg=%0d base=%0d tw=%0d cnt=%0d",
               nm, $time, g.valid, g.sf, g.fl, g.busy, g.done, g.inv, g.stage,
               g.base, g.tw, g.cnt, e.valid, e.sf, e.fl, e.busy, e.done,
               e.inv, e.stage, e.base, e.tw, e.cnt);
    end
  endtask

  // Monitor: one expectation per instance per clock edge.
  initial begin
    mdl_t e, g;
    g = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      if (q5.size() > 0) begin
        e = q5.pop_front();
        g.valid = i5.valid;  g.sf = i5.stage_first; g.fl = i5.frame_last;
        g.busy = i5.busy;    g.done = i5.done;      g.inv = i5.inv_q;
        g.stage = int'(i5.stage_sel); g.base = int'(i5.bfly_base);
        g.tw = int'(i5.tw_addr);      g.cnt = int'(i5.frame_cnt);
        cmp("n32", e, g);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        g.valid = i3.valid;  g.sf = i3.stage_first; g.fl = i3.frame_last;
        g.busy = i3.busy;    g.done = i3.done;      g.inv = i3.inv_q;
        g.stage = int'(i3.stage_sel); g.base = int'(i3.bfly_base);
        g.tw = int'(i3.tw_addr);      g.cnt = int'(i3.frame_cnt);
        cmp("n8", e, g);
      end
    end
  end

  // Stimulus
  initial begin
    m5 = '{default: 0};
    m3 = '{default: 0};
    rst5 = 1'b1; rst3 = 1'b1;
    i5.start = 0; i5.abort = 0; i5.en = 0; i5.cont = 0; i5.inv_in = 0;
    i3.start = 0; i3.abort = 0; i3.en = 0; i3.cont = 0; i3.inv_in = 0;

    // reset, then idle
    repeat (2) cyc(mk(1, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 0, 0));

    // single-shot frame
    cyc(mk(0, 1, 0, 1, 0, 1));
    repeat (16) cyc(mk(0, 0, 0, 1, 0, 0));

    // stall after the 2nd beat of stage 1 (N=8)
    cyc(mk(0, 1, 0, 1, 0, 0));
    repeat (5) cyc(mk(0, 0, 0, 1, 0, 0));
    repeat (3) cyc(mk(0, 0, 0, 0, 0, 0));
    repeat (12) cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 1, 0, 0));

    // back-to-back frames with inverse flag toggling
    cyc(mk(0, 1, 0, 1, 1, 1));
    for (int i = 0; i < 40; i++) cyc(mk(0, 0, 0, 1, 1, 1'(i % 2)));
    repeat (15) cyc(mk(0, 0, 0, 1, 0, 0));

    // abort on the stage-3 beat, with a simultaneous start
    cyc(mk(0, 1, 0, 1, 0, 0));
    repeat (3) cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 1, 1, 1, 0, 0));
    repeat (3) cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 1, 1, 0, 0));

    // reset mid-frame, then a clean frame
    cyc(mk(0, 1, 0, 1, 0, 1));
    repeat (2) cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(1, 0, 0, 1, 0, 0));
    cyc(mk(0, 1, 0, 1, 0, 0));
    repeat (16) cyc(mk(0, 0, 0, 1, 0, 0));

    // random control
    for (int i = 0; i < 3000; i++) cyc2(rnd(), rnd());

    repeat (4) cyc(mk(0, 0, 1, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Parametrised successor to the fixed 5-stage FFT mux-select counter.
- Sequences the radix-2 DIT stages of an N = 2^LOG2N point FFT, with P = 2^LOG2P butterflies processed per cycle.
- Per beat it emits the stage select, butterfly base index and twiddle ROM address to the datapath muxes.
- Adds start/abort/stall control, single-shot or back-to-back frame modes, a latched inverse flag, a frame counter and done reporting.

Parameters:
- LOG2N, 5, log2 of FFT size; legal range 2..12.
- LOG2P, 4, log2 of butterflies per cycle; legal range 0..LOG2N-1.
- SEL_W, 3, stage_sel width; must satisfy 2^SEL_W >= LOG2N.
- FRAME_W, 8, frame counter width.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a frame; sampled only in IDLE.
- abort, input, 1, synchronous cancel of the current frame.
- en, input, 1, advance enable; 0 stalls the sequence.
- cont, input, 1, continuous mode; sampled on the final beat of a frame.
- inv_in, input, 1, inverse-FFT request; latched on frame start.
- stage_sel, output, SEL_W, current stage 0..LOG2N-1.
- bfly_base, output, LOG2N-1, index of lane-0 butterfly in the current beat.
- tw_addr, output, LOG2N-1, twiddle exponent for lane-0 butterfly.
- valid, output, 1, outputs describe a live beat this cycle.
- stage_first, output, 1, first beat of a stage.
- frame_last, output, 1, final beat of a frame.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle frame-complete pulse.
- inv_q, output, 1, latched inverse flag.
- frame_cnt, output, FRAME_W, count of completed frames; wraps at its width.

Behaviour:
- All outputs are registered. On rst: state IDLE; every output is 0, including frame_cnt and inv_q.
- Derived constants:
  - C = 2^(LOG2N-1-LOG2P) beats per stage.
  - Beats per frame = LOG2N*C.
  - Internal beat counter b_cnt runs 0..C-1.
- States:
  - IDLE: busy=0, valid=0.
  - RUN: busy=1.
- IDLE -> RUN when start=1 and abort=0.
  - Latch inv_q <= inv_in; stage=0, b_cnt=0.
  - The first beat (valid=1, stage_first=1) appears in the next cycle. Latency from start to first beat is 1 cycle.
- RUN with en=1, one beat per cycle:
  - bfly_base = b_cnt << LOG2P.
  - tw_addr = (bfly_base mod 2^stage) << (LOG2N-1-stage), LOG2N-1 bits, unsigned, no overflow possible.
  - stage_first = 1 when b_cnt == 0.
  - frame_last = 1 when stage == LOG2N-1 and b_cnt == C-1.
  - b_cnt wraps C-1 -> 0 and stage increments.
- RUN with en=0:
  - valid=0; stage, b_cnt, inv_q and all index outputs hold.
  - stage_first and frame_last are forced to 0.
  - The sequence resumes on the next en=1 cycle.
- Final beat (frame_last beat with en=1), in the following cycle:
  - done=1 for exactly 1 cycle; frame_cnt increments.
  - If cont was 1 on the final beat: stay RUN with stage=0, b_cnt=0, inv_q relatched from inv_in sampled on the final beat. The next frame's first beat coincides with done, giving no gap.
  - If cont was 0: go to IDLE; busy=0 and valid=0 in the same cycle as done.
- abort=1 in RUN: next cycle goes to IDLE.
  - valid=0, busy=0.
  - No done pulse and frame_cnt unchanged, even when the aborted beat is the final beat.
- Simultaneous events:
  - abort together with start: abort wins, no frame starts.
  - abort in IDLE: no effect.
  - start while in RUN: ignored.
  - en=0 in IDLE: irrelevant.
- rst during RUN: immediately returns to the reset state on that edge; a frame in progress is discarded.
- Defaults (LOG2N=5, LOG2P=4): C=1, so stage_sel steps 0..4 on consecutive cycles. This is the behaviour of the fixed 5-stage counter, now with handshaking.

Test Plan:
- Defaults; start pulse at cycle 0, en=1, cont=0 -> cycles 1..5:
  - valid=1, stage_sel 0,1,2,3,4; bfly_base=0 and tw_addr=0 on every beat; stage_first=1 on every beat.
  - frame_last=1 at cycle 5.
  - Cycle 6: done=1, busy=0, frame_cnt=1.
- LOG2N=3, LOG2P=0 -> 12 beats:
  - Stage 0: tw_addr 0,0,0,0.
  - Stage 1: tw_addr 0,2,0,2.
  - Stage 2: tw_addr 0,1,2,3.
  - bfly_base on every stage: 0,1,2,3.
- LOG2N=3, LOG2P=0; en=0 for 3 cycles after the 2nd beat of stage 1 -> valid=0 and outputs hold (stage_sel=1, bfly_base=1) during the stall. Sequence resumes at bfly_base=2; done arrives 3 cycles later than in the unstalled run.
- Defaults; cont=1 held, inv_in toggled each frame -> stage_sel pattern 0..4 repeats back to back with no gap. done pulses together with each next frame's stage 0 beat; inv_q alternates per frame; frame_cnt counts 1,2,3.
- Defaults; abort on the stage-3 beat -> next cycle busy=0, valid=0, done never asserts, frame_cnt=0. A start issued in the same cycle as abort is ignored.
- rst=1 mid-frame at stage 2 -> next cycle all outputs are 0. A subsequent start produces a clean frame beginning at stage 0.
